result_writeback: RTL and testbench

//  Downstream of the output selector. Takes its scalar and 16-lane vector results and

---
 rtl/result_writeback_if.sv | 43 ++++
 rtl/result_writeback.sv | 189 ++++++++++++++++++
 tb/tb_result_writeback.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_writeback_if.sv
// result_writeback_if
//   Bundles the two data-path handshakes of the result writeback stage:
//   the selector-to-writeback result channel (in_*, round) and the
//   writeback-to-output-buffer write channel (wr_*).
//
//   master : the writeback block (accepts results, masters the buffer writes)
//   slave  : the surrounding environment (selector + output buffer)
//
//   Signals
//     in_valid   selector result valid
//     in_ready   writeback can accept a result
//     in_vector  LANES*DW selector vector, lane i = bits [DW*i +: DW]
//     in_scalar  DW selector scalar
//     round      k-sort round index fed back to the selector
//     wr_en      output-buffer write request
//     wr_addr    output-buffer write address
//     wr_data    output-buffer write data
//     wr_ready   buffer accepts the write this cycle
interface result_writeback_if #(
  parameter int LANES = 16,
  parameter int DW    = 32,
  parameter int AW    = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_vector;
  logic [DW-1:0]         in_scalar;
  logic [31:0]           round;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;
  logic                  wr_ready;

  modport master (
    input  in_valid, in_vector, in_scalar, wr_ready,
    output in_ready, round, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_vector, in_scalar, wr_ready,
    input  in_ready, round, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/result_writeback.sv
// result_writeback
//   Sits downstream of the output selector. Captures one scalar or one
//   LANES-wide vector result per line and serialises it, one DW-bit word per
//   cycle, into the output buffer. In k-sort mode the 2*K result words
//   (values then indices) are fetched in rounds of up to LANES words; the
//   current round index is driven back to the selector.
//
//   Ports
//     clk, rst      clock, synchronous active-high reset
//     i_start       1-cycle pulse, latches i_base_addr / i_mode / i_num_items
//     i_base_addr   first output-buffer address
//     i_mode        0=vector, 1=scalar, 2=k-sort, 3=reserved (finishes, no writes)
//     i_num_items   vectors or scalars to write (ignored in k-sort mode)
//     bus           result_writeback_if.master (result input + buffer write)
//     o_busy        high while loading/draining
//     o_done        1-cycle completion pulse
//     o_err         (WB_WRAP_ERR_EN only) address-wrap error, sticky until next start
//
//   Optional feature macro: WB_WRAP_ERR_EN
//     defined   : a write that would land after wr_addr wrapped past 2^AW-1 is
//                 suppressed, the job finishes early and o_err is raised.
//     undefined : the address wraps silently and writing continues.
module result_writeback #(
  parameter int LANES = 16,
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter int K     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [AW-1:0]      i_base_addr,
  input  logic [1:0]         i_mode,
  input  logic [15:0]        i_num_items,
  result_writeback_if.master bus,
  output logic               o_busy,
  output logic               o_done
`ifdef WB_WRAP_ERR_EN
  ,
  output logic               o_err
`endif
);

  localparam int          IDXW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [31:0] KS_WORDS = 32'(2 * K);
  localparam logic [31:0] LANES_W  = 32'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_FIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_mode;
  logic [15:0]       r_numItems;
  logic [15:0]       r_itemCnt;
  logic [AW-1:0]     r_addr;
  logic [31:0]       r_round;
  logic [IDXW-1:0]   r_wordIdx;
  logic [DW-1:0]     r_line [LANES];

  logic [31:0]       w_ksRemain;
  logic [31:0]       w_lineWords;
  logic              w_lastWord;
  logic              w_lastLine;
  logic              w_retire;
  logic              w_wrapBlock;
  logic              w_empty;

`ifdef WB_WRAP_ERR_EN
  logic              r_wrapPending;
  logic              r_err;
  // Once a word has been retired at the top address, the next write would
  // land at the wrapped address, so it is blocked instead.
  assign w_wrapBlock = r_wrapPending;
  assign o_err       = r_err;
`else
  assign w_wrapBlock = 1'b0;
`endif

  // Words in the current line; in k-sort mode the final round is short
  // (for K=20: 16, 16, 8).
  always_comb begin
    w_ksRemain = KS_WORDS - LANES_W * r_round;
    case (r_mode)
      2'd0:    w_lineWords = LANES_W;
      2'd1:    w_lineWords = 32'd1;
      default: w_lineWords = (w_ksRemain < LANES_W) ? w_ksRemain : LANES_W;
    endcase
  end

  assign w_lastWord = (32'(r_wordIdx) == w_lineWords - 32'd1);
  assign w_lastLine = (r_mode == 2'd2) ? (LANES_W * (r_round + 32'd1) >= KS_WORDS)
                                       : (r_itemCnt + 16'd1 == r_numItems);
  assign w_empty    = (i_mode == 2'd3) || ((i_mode != 2'd2) && (i_num_items == 16'd0));
  assign w_retire   = (r_state == S_DRAIN) && !w_wrapBlock && bus.wr_ready;

  // Next-state and output decode.
  always_comb begin
    w_next       = r_state;
    bus.in_ready = 1'b0;
    bus.wr_en    = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = w_empty ? S_FIN : S_LOAD;
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        o_busy       = 1'b1;
        if (bus.in_valid) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy    = 1'b1;
        bus.wr_en = !w_wrapBlock;
        if (w_wrapBlock)                  w_next = S_FIN;
        else if (w_retire && w_lastWord)  w_next = w_lastLine ? S_FIN : S_LOAD;
      end
      S_FIN: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.wr_addr = r_addr;
  assign bus.wr_data = r_line[r_wordIdx];
  assign bus.round   = r_round;

  // State, job parameters, counters and the line register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'd0;
      r_numItems <= 16'd0;
      r_itemCnt  <= 16'd0;
      r_addr     <= '0;
      r_round    <= 32'd0;
      r_wordIdx  <= '0;
      for (int i = 0; i < LANES; i++) r_line[i] <= '0;
`ifdef WB_WRAP_ERR_EN
      r_wrapPending <= 1'b0;
      r_err         <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode     <= i_mode;
            r_numItems <= i_num_items;
            r_addr     <= i_base_addr;
            r_itemCnt  <= 16'd0;
            r_round    <= 32'd0;
            r_wordIdx  <= '0;
`ifdef WB_WRAP_ERR_EN
            r_wrapPending <= 1'b0;
            r_err         <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            if (r_mode == 2'd1) r_line[0] <= bus.in_scalar;
            else for (int i = 0; i < LANES; i++) r_line[i] <= bus.in_vector[i*DW +: DW];
          end
        end
        S_DRAIN: begin
`ifdef WB_WRAP_ERR_EN
          if (w_wrapBlock) r_err <= 1'b1;
          if (w_retire && (&r_addr)) r_wrapPending <= 1'b1;
`endif
          if (w_retire) begin
            r_addr <= r_addr + 1'b1;
            if (w_lastWord) begin
              r_wordIdx <= '0;
              if (r_mode == 2'd2) r_round   <= r_round + 32'd1;
              else                r_itemCnt <= r_itemCnt + 16'd1;
            end else begin
              r_wordIdx <= r_wordIdx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback
//   Randomised self-checking bench for result_writeback. Each job's expected
//   write stream is derived from a flat word index (address = base + w,
//   data = lane w%perLine of selector line w/perLine) and compared with the
//   writes the buffer actually accepted.
module tb_result_writeback;
  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int K     = 20;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] baseAddr;
  logic [1:0]    mode;
  logic [15:0]   numItems;
  logic          busy;
  logic          done;
`ifdef WB_WRAP_ERR_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  result_writeback_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus ();

  result_writeback #(.LANES(LANES), .DW(DW), .AW(AW), .K(K)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_base_addr (baseAddr),
    .i_mode      (mode),
    .i_num_items (numItems),
    .bus         (bus.master),
    .o_busy      (busy),
    .o_done      (done)
`ifdef WB_WRAP_ERR_EN
    ,
    .o_err       (err)
`endif
  );

  int   nVectors     = 0;
  int   nMiscompares = 0;

  logic [LANES*DW-1:0] lineVec    [8];
  logic [DW-1:0]       lineScalar [8];

  wr_t  expQ[$];
  wr_t  obsQ[$];
  int   roundQ[$];
  logic expErr;

  bit           timedOut;
  int           doneCnt;
  int           doneCycle;
  int           capCnt;
  int           stallBad;
  logic         busyAfterStart;
  logic [127:0] rstSnap;

  task automatic fillLines();
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < LANES; l++) lineVec[i][DW*l +: DW] = $urandom;
      lineScalar[i] = $urandom;
    end
  endtask

  // Reference stream: word w of the job goes to base+w and carries lane
  // (w % perLine) of the w/perLine-th result the selector delivered.
  task automatic buildExpected(input int m, input int base, input int num);
    int  total, perLine, line, lane, absAddr;
    wr_t e;
    expQ.delete();
    expErr = 1'b0;
    case (m)
      0:       begin total = num * LANES; perLine = LANES; end
      1:       begin total = num;         perLine = 1;     end
      2:       begin total = 2 * K;       perLine = LANES; end
      default: begin total = 0;           perLine = 1;     end
    endcase
    for (int w = 0; w < total; w++) begin
      absAddr = base + w;
`ifdef WB_WRAP_ERR_EN
      if (absAddr >= (1 << AW)) begin
        expErr = 1'b1;
        break;
      end
`endif
      line   = w / perLine;
      lane   = w % perLine;
      e.addr = AW'(absAddr % (1 << AW));
      e.data = (m == 1) ? lineScalar[line] : lineVec[line][DW*lane +: DW];
      expQ.push_back(e);
    end
  endtask

  // Drives one job and records what the DUT did. readyMode: 0 always ready,
  // 1 ready one cycle in three, 2 random. validMode: 0 always valid, else
  // random. reStartAt >= 0 pulses a conflicting start at that cycle.
  // rstAfterWords >= 0 asserts reset once that many words were accepted.
  task automatic runJob(input int m, input int base, input int num, input int readyMode,
                        input int validMode, input int reStartAt, input int rstAfterWords);
    int            cyc;
    bit            prevStall;
    logic [AW-1:0] prevAddr;
    logic [DW-1:0] prevData;
    obsQ.delete();
    roundQ.delete();
    timedOut = 1'b0; doneCnt = 0; doneCycle = -1; capCnt = 0; stallBad = 0;
    busyAfterStart = 1'b0; rstSnap = '1;
    prevStall = 1'b0; prevAddr = '0; prevData = '0; cyc = 0;
    forever begin
      @(posedge clk); #1;
      if (rstAfterWords >= 0 && obsQ.size() >= rstAfterWords) begin
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstSnap = {bus.in_ready, bus.round, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done};
`ifdef WB_WRAP_ERR_EN
        rstSnap[127] = err;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      start = (cyc == 0) || (cyc == reStartAt);
      if (cyc == 0) begin
        baseAddr = AW'(base); mode = 2'(m); numItems = 16'(num);
      end else if (cyc == reStartAt) begin
        baseAddr = AW'(base + 'h55); mode = 2'd0; numItems = 16'd7;
      end
      case (readyMode)
        0:       bus.wr_ready = 1'b1;
        1:       bus.wr_ready = (cyc % 3 == 0);
        default: bus.wr_ready = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid  = (validMode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.in_vector = lineVec[capCnt % 8];
      bus.in_scalar = lineScalar[capCnt % 8];
      @(negedge clk);
      if (cyc == 1) busyAfterStart = busy;
      if (prevStall && (!bus.wr_en || bus.wr_addr !== prevAddr || bus.wr_data !== prevData))
        stallBad++;
      prevStall = bus.wr_en && !bus.wr_ready;
      prevAddr  = bus.wr_addr;
      prevData  = bus.wr_data;
      if (bus.in_valid && bus.in_ready) begin
        roundQ.push_back(int'(bus.round));
        capCnt++;
      end
      if (bus.wr_en && bus.wr_ready) obsQ.push_back({bus.wr_addr, bus.wr_data});
      if (done) begin
        doneCnt++;
        if (doneCycle < 0) doneCycle = cyc;
      end
      if (doneCycle >= 0 && cyc >= doneCycle + 3) break;
      cyc++;
      if (cyc > 3000) begin
        timedOut = 1'b1;
        break;
      end
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; baseAddr = '0; mode = 2'd0; numItems = 16'd0;
    bus.in_valid = 1'b0; bus.in_vector = '0; bus.in_scalar = '0; bus.wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nVectors += 6;
    if (bus.in_ready !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    if (bus.round !== 32'd0)   begin nMiscompares++; $display("[TB] FAIL reset_round: got %h expected 0", bus.round); end
    if (bus.wr_en !== 1'b0)    begin nMiscompares++; $display("[TB] FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
    if (bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      nMiscompares++; $display("[TB] FAIL reset_wr_bus: got addr=%h data=%h expected 0/0", bus.wr_addr, bus.wr_data);
    end
    if (busy !== 1'b0)         begin nMiscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)         begin nMiscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
`ifdef WB_WRAP_ERR_EN
    nVectors++;
    if (err !== 1'b0)          begin nMiscompares++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_vector();
    fillLines();
    buildExpected(0, 'h100, 2);
    runJob(0, 'h100, 2, 0, 0, -1, -1);
    nVectors += 5;
    if (timedOut)             begin nMiscompares++; $display("[TB] FAIL vector_timeout: no done within budget"); end
    if (obsQ.size() != 32)    begin nMiscompares++; $display("[TB] FAIL vector_count: got %0d writes expected 32", obsQ.size()); end
    if (doneCnt != 1)         begin nMiscompares++; $display("[TB] FAIL vector_done: got %0d pulses expected 1", doneCnt); end
    if (capCnt != 2)          begin nMiscompares++; $display("[TB] FAIL vector_captures: got %0d expected 2", capCnt); end
    if (busyAfterStart !== 1'b1) begin nMiscompares++; $display("[TB] FAIL vector_busy: got %b expected 1", busyAfterStart); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      nVectors++;
      if (obsQ[i] !== expQ[i]) begin
        nMiscompares++;
        $display("[TB] FAIL vector_word%0d: got %h/%h expected %h/%h", i, obsQ[i].addr, obsQ[i].data, expQ[i].addr, expQ[i].data);
      end
    end
  endtask

  task automatic test_ksort();
    fillLines();
    buildExpected(2, 0, 0);
    runJob(2, 0, 0, 0, 1, -1, -1);
    nVectors += 4;
    if (timedOut)             begin nMiscompares++; $display("[TB] FAIL ksort_timeout: no done within budget"); end
    if (obsQ.size() != 2*K)   begin nMiscompares++; $display("[TB] FAIL ksort_count: got %0d writes expected %0d", obsQ.size(), 2*K); end
    if (doneCnt != 1)         begin nMiscompares++; $display("[TB] FAIL ksort_done: got %0d pulses expected 1", doneCnt); end
    if (roundQ.size() != 3)   begin nMiscompares++; $display("[TB] FAIL ksort_rounds: got %0d loads expected 3", roundQ.size()); end
    for (int i = 0; i < roundQ.size(); i++) begin
      nVectors++;
      if (roundQ[i] != i) begin nMiscompares++; $display("[TB] FAIL ksort_round%0d: got %0d expected %0d", i, roundQ[i], i); end
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      nVectors++;
      if (obsQ[i] !== expQ[i]) begin
        nMiscompares++;
        $display("[TB] FAIL ksort_word%0d: got %h/%h expected %h/%h", i, obsQ[i].addr, obsQ[i].data, expQ[i].addr, expQ[i].data);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    fillLines();
    base = $urandom_range(0, 'h300);
    buildExpected(0, base, 3);
    runJob(0, base, 3, 1, 1, -1, -1);
    nVectors += 4;
    if (timedOut)                  begin nMiscompares++; $display("[TB] FAIL bp_timeout: no done within budget"); end
    if (stallBad != 0)             begin nMiscompares++; $display("[TB] FAIL bp_hold: got %0d unstable stalls expected 0", stallBad); end
    if (obsQ.size() != expQ.size()) begin nMiscompares++; $display("[TB] FAIL bp_count: got %0d writes expected %0d", obsQ.size(), expQ.size()); end
    if (doneCnt != 1)              begin nMiscompares++; $display("[TB] FAIL bp_done: got %0d pulses expected 1", doneCnt); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      nVectors++;
      if (obsQ[i] !== expQ[i]) begin
        nMiscompares++;
        $display("[TB] FAIL bp_word%0d: got %h/%h expected %h/%h", i, obsQ[i].addr, obsQ[i].data, expQ[i].addr, expQ[i].data);
      end
    end
  endtask

  task automatic test_zero_items();
    fillLines();
    buildExpected(1, 'h010, 0);
    runJob(1, 'h010, 0, 0, 0, -1, -1);
    nVectors += 4;
    if (obsQ.size() != 0) begin nMiscompares++; $display("[TB] FAIL zero_count: got %0d writes expected 0", obsQ.size()); end
    if (doneCnt != 1)     begin nMiscompares++; $display("[TB] FAIL zero_done: got %0d pulses expected 1", doneCnt); end
    if (doneCycle != 1)   begin nMiscompares++; $display("[TB] FAIL zero_done_cycle: got %0d expected 1", doneCycle); end
    if (capCnt != 0)      begin nMiscompares++; $display("[TB] FAIL zero_captures: got %0d expected 0", capCnt); end
    // A second start arriving mid-job must not disturb the running job.
    fillLines();
    buildExpected(1, 'h200, 3);
    runJob(1, 'h200, 3, 2, 1, 4, -1);
    nVectors += 2;
    if (obsQ.size() != 3) begin nMiscompares++; $display("[TB] FAIL restart_count: got %0d writes expected 3", obsQ.size()); end
    if (doneCnt != 1)     begin nMiscompares++; $display("[TB] FAIL restart_done: got %0d pulses expected 1", doneCnt); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      nVectors++;
      if (obsQ[i] !== expQ[i]) begin
        nMiscompares++;
        $display("[TB] FAIL restart_word%0d: got %h/%h expected %h/%h", i, obsQ[i].addr, obsQ[i].data, expQ[i].addr, expQ[i].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    fillLines();
    runJob(0, 'h040, 2, 0, 0, -1, 5);
    nVectors++;
    if (rstSnap !== '0) begin nMiscompares++; $display("[TB] FAIL midreset_outputs: got %h expected 0", rstSnap); end
    fillLines();
    buildExpected(0, 'h080, 1);
    runJob(0, 'h080, 1, 0, 0, -1, -1);
    nVectors += 3;
    if (timedOut)          begin nMiscompares++; $display("[TB] FAIL midreset_timeout: no done within budget"); end
    if (obsQ.size() != 16) begin nMiscompares++; $display("[TB] FAIL midreset_count: got %0d writes expected 16", obsQ.size()); end
    if (doneCnt != 1)      begin nMiscompares++; $display("[TB] FAIL midreset_done: got %0d pulses expected 1", doneCnt); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      nVectors++;
      if (obsQ[i] !== expQ[i]) begin
        nMiscompares++;
        $display("[TB] FAIL midreset_word%0d: got %h/%h expected %h/%h", i, obsQ[i].addr, obsQ[i].data, expQ[i].addr, expQ[i].data);
      end
    end
  endtask

  task automatic test_wrap();
    fillLines();
    buildExpected(0, 'h3F8, 1);
    runJob(0, 'h3F8, 1, 0, 0, -1, -1);
    nVectors += 3;
    if (timedOut)                  begin nMiscompares++; $display("[TB] FAIL wrap_timeout: no done within budget"); end
    if (obsQ.size() != expQ.size()) begin nMiscompares++; $display("[TB] FAIL wrap_count: got %0d writes expected %0d", obsQ.size(), expQ.size()); end
    if (doneCnt != 1)              begin nMiscompares++; $display("[TB] FAIL wrap_done: got %0d pulses expected 1", doneCnt); end
`ifdef WB_WRAP_ERR_EN
    nVectors++;
    if (err !== expErr) begin nMiscompares++; $display("[TB] FAIL wrap_err: got %b expected %b", err, expErr); end
`endif
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      nVectors++;
      if (obsQ[i] !== expQ[i]) begin
        nMiscompares++;
        $display("[TB] FAIL wrap_word%0d: got %h/%h expected %h/%h", i, obsQ[i].addr, obsQ[i].data, expQ[i].addr, expQ[i].data);
      end
    end
  endtask

  task automatic test_random();
    int m, base, num;
    for (int j = 0; j < 8; j++) begin
      fillLines();
      m    = $urandom_range(0, 3);
      base = $urandom_range(0, (1 << AW) - 1);
      num  = $urandom_range(0, 4);
      buildExpected(m, base, num);
      runJob(m, base, num, $urandom_range(0, 2), 1, -1, -1);
      nVectors += 4;
      if (timedOut)                  begin nMiscompares++; $display("[TB] FAIL rand%0d_timeout: no done within budget", j); end
      if (obsQ.size() != expQ.size()) begin nMiscompares++; $display("[TB] FAIL rand%0d_count: got %0d writes expected %0d", j, obsQ.size(), expQ.size()); end
      if (doneCnt != 1)              begin nMiscompares++; $display("[TB] FAIL rand%0d_done: got %0d pulses expected 1", j, doneCnt); end
      if (stallBad != 0)             begin nMiscompares++; $display("[TB] FAIL rand%0d_hold: got %0d unstable stalls expected 0", j, stallBad); end
`ifdef WB_WRAP_ERR_EN
      nVectors++;
      if (err !== expErr) begin nMiscompares++; $display("[TB] FAIL rand%0d_err: got %b expected %b", j, err, expErr); end
`endif
      for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
        nVectors++;
        if (obsQ[i] !== expQ[i]) begin
          nMiscompares++;
          $display("[TB] FAIL rand%0d_word%0d: got %h/%h expected %h/%h", j, i, obsQ[i].addr, obsQ[i].data, expQ[i].addr, expQ[i].data);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] result_writeback bench starting");
    test_reset();
    test_vector();
    test_ksort();
    test_backpressure();
    test_zero_items();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
